// File: rtl/unmsk_subword_seq_pkg.sv
// unmsk_subword_seq_pkg: state encoding, constants and GF(2^8)/byte helpers
// shared by the byte-serial SubWord sequencer and its S-box.
package unmsk_subword_seq_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int SW_NB = 4;
    localparam logic [7:0] SW_RCON_INIT = 8'h01;
    localparam logic [7:0] XTIME_RED = 8'h1B;

    // byte 0 is the most significant byte of the word
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
        return w[8*(3-int'(i)) +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i, input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*(3-int'(i)) +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_RED : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 as the product of x^(2^k), k = 1..7; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r = gmul(r, sq);
        end
        return r;
    endfunction
endpackage

// File: rtl/unmsk_sbox.sv
// unmsk_sbox: unmasked AES S-box, forward or inverse; u[7] = u0 and o[7] = o0.
module unmsk_sbox
    import unmsk_subword_seq_pkg::*;
(
    input  logic [7:0] u,
    input  logic       inverse,
    output logic [7:0] o
);
    logic [7:0] pre, inv_v;

    assign pre = inverse ? rotl8(u, 1) ^ rotl8(u, 3) ^ rotl8(u, 6) ^ 8'h05 : u;
    assign inv_v = gf_inv(pre);
    assign o = inverse ? inv_v
                       : inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3) ^ rotl8(inv_v, 4) ^ 8'h63;
endmodule

// File: rtl/unmsk_subword_seq.sv
// unmsk_subword_seq: byte-serial SubWord over one shared S-box.
// UNMSK_SUBWORD_RCON_EN adds RotWord + Rcon for the key schedule.
module unmsk_subword_seq
    import unmsk_subword_seq_pkg::*;
#(
`ifdef UNMSK_SUBWORD_RCON_EN
    parameter logic [7:0] RCON_INIT = SW_RCON_INIT,
`endif
    parameter int NB = SW_NB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_inverse,
`ifdef UNMSK_SUBWORD_RCON_EN
    input  logic        rot_en,
    input  logic        rcon_clr,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);
    state_t      state, state_nx;
    logic [1:0]  cnt;
    logic [31:0] word_q, res;
    logic        inv_q, acc, hs;
    logic [7:0]  s_in, s_out;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign acc = in_valid & in_ready;
    assign hs = out_valid & out_ready;
    // outside BUSY the S-box sees latched byte 0 so it stays quiet
    assign s_in = get_byte(word_q, state == BUSY ? cnt : 2'd0);

    unmsk_sbox u_sbox (.u(s_in), .inverse(inv_q), .o(s_out));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (acc) state_nx = BUSY;
        else if (state == BUSY && cnt == 2'(NB - 1)) state_nx = DONE;
        else if (hs) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= 2'd0;
            word_q <= 32'h0;
            inv_q <= 1'b0;
            res <= 32'h0;
        end else if (acc) begin
            word_q <= in_word;
            inv_q <= in_inverse;
            cnt <= 2'd0;
        end else if (state == BUSY) begin
            res <= put_byte(res, cnt, s_out);
            cnt <= cnt + 2'd1;
        end

`ifdef UNMSK_SUBWORD_RCON_EN
    logic       rot_q;
    logic [7:0] rcon;

    // a clear wins over an advance landing in the same cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rot_q <= 1'b0;
            rcon <= RCON_INIT;
        end else begin
            if (acc) rot_q <= rot_en;
            if (rcon_clr) rcon <= RCON_INIT;
            else if (hs && rot_q) rcon <= xtime(rcon);
        end

    assign out_word = rot_q ? {res[23:0], res[31:24]} ^ {rcon, 24'h0} : res;
`else
    assign out_word = res;
`endif
endmodule
